// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 master, MSB-first, SCK divided from clk, start/busy/done handshake.
// A start seen on the closing edge of GAP begins the next frame at once, so the nCS-high gap is half cycles.
module spi_master_tx #(
    parameter int width = 16,
    parameter int half  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [width-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] rx_data,
    input  logic             MISO,
    output logic             nCS,
    output logic             SCK,
    output logic             MOSI
);
    localparam int HW = ($clog2(half) < 1) ? 1 : $clog2(half);
    localparam int BW = $clog2(width);
    localparam logic [HW-1:0] H_LAST = HW'(half - 1);
    localparam logic [BW-1:0] B_LAST = BW'(width - 1);
    localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, HIGH = 3'd2, LOW = 3'd3, HOLD = 3'd4, GAP = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [width-1:0] tx_q, tx_d, rxs_q, rxs_d, rx_q, rx_d;
    logic             ncs_q, ncs_d, sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
    logic             tick, accept;

    assign tick   = hcnt_q == H_LAST;
    assign accept = start && (state_q == IDLE || (state_q == GAP && tick));

    always_comb begin
        state_d = state_q;
        hcnt_d  = (state_q == IDLE || tick) ? '0 : hcnt_q + HW'(1);
        bcnt_d  = bcnt_q;
        tx_d    = tx_q;
        rxs_d   = rxs_q;
        rx_d    = rx_q;
        ncs_d   = ncs_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            SETUP, LOW: if (tick) begin
                sck_d   = 1'b1;
                rxs_d   = {rxs_q[width-2:0], MISO};
                state_d = HIGH;
            end
            HIGH: if (tick) begin
                sck_d = 1'b0;
                if (bcnt_q == B_LAST) begin
                    state_d = HOLD;
                end else begin
                    bcnt_d  = bcnt_q + BW'(1);
                    tx_d    = tx_q << 1;
                    mosi_d  = tx_q[width-2];
                    state_d = LOW;
                end
            end
            HOLD: if (tick) begin
                ncs_d   = 1'b1;
                mosi_d  = 1'b0;
                state_d = GAP;
            end
            GAP: if (tick) begin
                rx_d    = rxs_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            IDLE: ;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            tx_d    = tx_data;
            ncs_d   = 1'b0;
            mosi_d  = tx_data[width-1];
            busy_d  = 1'b1;
            bcnt_d  = '0;
            state_d = SETUP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            tx_q    <= '0;
            rxs_q   <= '0;
            rx_q    <= '0;
            ncs_q   <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            bcnt_q  <= bcnt_d;
            tx_q    <= tx_d;
            rxs_q   <= rxs_d;
            rx_q    <= rx_d;
            ncs_q   <= ncs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign nCS     = ncs_q;
    assign SCK     = sck_q;
    assign MOSI    = mosi_q;
endmodule
